// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage in front of the IF/ID pipeline register. Generates the PC and
//   fetches one instruction at a time over a req/addr_ok/data_ok SRAM port, with at most one
//   request outstanding. The fetched {pc, inst} is held until ID takes it. A branch or
//   exception flush redirects the PC, and the response of a cancelled fetch is dropped.
//
//   Configuration macro: IF_ADEF_CHECK_EN
//     defined   : a misaligned pc_r (pc_r[1:0] != 0) issues no request. The stage presents
//                 {pc_r, 0} to ID with if_to_obus[0] = 1 (ADEF).
//     undefined : the PC is not checked, and if_to_obus is always 0.
//
//   Ports
//     clk                  clock, all state changes on posedge
//     rst_n                synchronous reset, active HIGH despite the name
//     id_allowin_i         ID can accept this cycle
//     branch_flush_i       branch redirect, target on branch_target_i
//     excep_flush_i        exception/ertn redirect, entry on excep_entry_i (beats branch)
//     inst_sram_req_o      fetch request, address on inst_sram_addr_o (= pc_r)
//     inst_sram_addr_ok_i  request accepted this cycle
//     inst_sram_data_ok_i  read data inst_sram_rdata_i returned this cycle
//     if_to_id_valid_o     {pc, inst} on pc_inst_obus is valid for ID
//     if_to_obus           side-band to ID, bit0 = ADEF
//
//   state  | meaning
//   S_REQ  | request pc_r until the SRAM accepts it
//   S_WAIT | one request outstanding, waiting for data_ok
//   S_HOLD | {pc, inst} presented to ID, waiting for allowin
module if_fetch_stage #(
  parameter int                PC_W       = 32,
  parameter int                INST_W     = 32,
  parameter int                IF_TO_ID_W = 8,
  parameter logic [PC_W-1:0]   RESET_PC   = 32'h1C000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_allowin_i,
  input  logic                   branch_flush_i,
  input  logic [PC_W-1:0]        branch_target_i,
  input  logic                   excep_flush_i,
  input  logic [PC_W-1:0]        excep_entry_i,
  output logic                   inst_sram_req_o,
  output logic [PC_W-1:0]        inst_sram_addr_o,
  input  logic                   inst_sram_addr_ok_i,
  input  logic                   inst_sram_data_ok_i,
  input  logic [INST_W-1:0]      inst_sram_rdata_i,
  output logic                   if_to_id_valid_o,
  output logic [PC_W+INST_W-1:0] pc_inst_obus,
  output logic [IF_TO_ID_W-1:0]  if_to_obus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t                 r_state, w_state_nxt;
  logic [PC_W-1:0]        r_pc, w_pc_nxt;
  logic                   r_cancel, w_cancel_nxt;
  logic [PC_W+INST_W-1:0] r_pc_inst, w_pc_inst_nxt;
  logic [IF_TO_ID_W-1:0]  r_side, w_side_nxt;
  logic                   w_req;
  logic                   w_flush;
  logic [PC_W-1:0]        w_tgt;
  logic                   w_misalign;

  assign w_flush = excep_flush_i | branch_flush_i;
  assign w_tgt   = excep_flush_i ? excep_entry_i : branch_target_i;

`ifdef IF_ADEF_CHECK_EN
  assign w_misalign = (r_pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_cancel  <= 1'b0;
      r_pc_inst <= '0;
      r_side    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_cancel  <= w_cancel_nxt;
      r_pc_inst <= w_pc_inst_nxt;
      r_side    <= w_side_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_cancel_nxt  = r_cancel;
    w_pc_inst_nxt = r_pc_inst;
    w_side_nxt    = r_side;
    w_req         = 1'b0;
    case (r_state)
      S_REQ: begin
        w_req = ~w_misalign;
        if (w_misalign) begin
          if (w_flush) begin
            w_pc_nxt = w_tgt;
          end else begin
            // Misaligned fetch goes to ID as an ADEF bubble instead of touching the SRAM.
            w_state_nxt   = S_HOLD;
            w_pc_inst_nxt = {r_pc, {INST_W{1'b0}}};
            w_side_nxt    = {{(IF_TO_ID_W-1){1'b0}}, 1'b1};
          end
        end else if (inst_sram_addr_ok_i) begin
          w_state_nxt = S_WAIT;
          // The accepted request is already in flight; mark its answer for disposal.
          if (w_flush) begin
            w_cancel_nxt = 1'b1;
            w_pc_nxt     = w_tgt;
          end
        end else if (w_flush) begin
          w_pc_nxt = w_tgt;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok_i) begin
          w_cancel_nxt = 1'b0;
          if (r_cancel || w_flush) begin
            w_state_nxt = S_REQ;
            if (w_flush) w_pc_nxt = w_tgt;
          end else begin
            w_state_nxt   = S_HOLD;
            w_pc_inst_nxt = {r_pc, inst_sram_rdata_i};
            w_side_nxt    = '0;
          end
        end else if (w_flush) begin
          w_cancel_nxt = 1'b1;
          w_pc_nxt     = w_tgt;
        end
      end
      S_HOLD: begin
        if (w_flush) begin
          w_state_nxt   = S_REQ;
          w_pc_nxt      = w_tgt;
          w_pc_inst_nxt = '0;
          w_side_nxt    = '0;
        end else if (id_allowin_i) begin
          w_state_nxt   = S_REQ;
          w_pc_nxt      = r_pc + PC_W'(4);
          w_pc_inst_nxt = '0;
          w_side_nxt    = '0;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // Request is masked during the reset cycle, whatever state the register holds.
  assign inst_sram_req_o  = w_req & ~rst_n;
  assign inst_sram_addr_o = r_pc;
  assign if_to_id_valid_o = (r_state == S_HOLD);
  assign pc_inst_obus     = r_pc_inst;
  assign if_to_obus       = r_side;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [7:0]  side;
  } pres_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        id_allowin_i = 1'b0;
  logic        branch_flush_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        excep_flush_i = 1'b0;
  logic [31:0] excep_entry_i = '0;
  logic        inst_sram_req_o;
  logic [31:0] inst_sram_addr_o;
  logic        inst_sram_addr_ok_i;
  logic        inst_sram_data_ok_i;
  logic [31:0] inst_sram_rdata_i;
  logic        if_to_id_valid_o;
  logic [63:0] pc_inst_obus;
  logic [7:0]  if_to_obus;

  if_fetch_stage dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .id_allowin_i        (id_allowin_i),
    .branch_flush_i      (branch_flush_i),
    .branch_target_i     (branch_target_i),
    .excep_flush_i       (excep_flush_i),
    .excep_entry_i       (excep_entry_i),
    .inst_sram_req_o     (inst_sram_req_o),
    .inst_sram_addr_o    (inst_sram_addr_o),
    .inst_sram_addr_ok_i (inst_sram_addr_ok_i),
    .inst_sram_data_ok_i (inst_sram_data_ok_i),
    .inst_sram_rdata_i   (inst_sram_rdata_i),
    .if_to_id_valid_o    (if_to_id_valid_o),
    .pc_inst_obus        (pc_inst_obus),
    .if_to_obus          (if_to_obus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Scoreboard queues, filled by the stimulus before the DUT acts.
  logic [31:0] exp_addr_q[$];
  pres_t       exp_pres_q[$];

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic push_pres(input logic [31:0] pc, input logic [31:0] inst, input logic [7:0] side);
    pres_t p;
    p.pc = pc; p.inst = inst; p.side = side;
    exp_pres_q.push_back(p);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: grants while budget remains, answers delay cycles after the grant.
  int          budget = 0;
  int          delay = 1;
  int          pend = 0;
  logic [31:0] pend_data = '0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = '0;
  int          grant_cnt = 0;
  int          grant_cyc = 0;
  int          grant_gap = 0;

  initial begin
    inst_sram_addr_ok_i = 1'b0;
    inst_sram_data_ok_i = 1'b0;
    inst_sram_rdata_i   = '0;
    forever begin
      @(posedge clk); #1;
      inst_sram_addr_ok_i = 1'b0;
      inst_sram_data_ok_i = 1'b0;
      if (rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            inst_sram_data_ok_i = 1'b1;
            inst_sram_rdata_i   = pend_data;
          end
        end
        if (inst_sram_req_o && budget > 0 && pend == 0 && !inst_sram_data_ok_i) begin
          inst_sram_addr_ok_i = 1'b1;
          budget--;
          grant_cnt++;
          grant_gap = cyc - grant_cyc;
          grant_cyc = cyc;
          pend = delay;
          pend_data = ovr_en ? ovr_data : rd_of(inst_sram_addr_o);
          if (exp_addr_q.size() == 0) check_val("req_unexpected", {32'h0, inst_sram_addr_o}, 64'h0);
          else check_val("req_addr", {32'h0, inst_sram_addr_o}, {32'h0, exp_addr_q.pop_front()});
        end
      end
    end
  end

  // Presentation monitor.
  pres_t cur;
  logic  prev_valid = 1'b0;
  int    pres_cnt = 0;
  int    lat_last = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (if_to_id_valid_o) begin
        if (!prev_valid) begin
          pres_cnt++;
          lat_last = cyc - grant_cyc;
          if (exp_pres_q.size() == 0) begin
            check_val("pres_unexpected", pc_inst_obus, 64'h0);
          end else begin
            cur = exp_pres_q.pop_front();
            check_val("pres_pc", {32'h0, pc_inst_obus[63:32]}, {32'h0, cur.pc});
            check_val("pres_inst", {32'h0, pc_inst_obus[31:0]}, {32'h0, cur.inst});
            check_val("pres_side", {56'h0, if_to_obus}, {56'h0, cur.side});
          end
        end else begin
          check_val("hold_stable", pc_inst_obus, {cur.pc, cur.inst});
        end
        check_val("req_in_hold", {63'h0, inst_sram_req_o}, 64'h0);
      end
      prev_valid = if_to_id_valid_o;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_pres(input int n, input int maxc);
    int c = 0;
    while (pres_cnt < n && c < maxc) begin tick(); c++; end
    check_val("wait_pres_timeout", {63'h0, pres_cnt >= n}, 64'h1);
  endtask

  task automatic wait_grant(input int n, input int maxc);
    int c = 0;
    while (grant_cnt < n && c < maxc) begin tick(); c++; end
    check_val("wait_grant_timeout", {63'h0, grant_cnt >= n}, 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, g0;
    // Reset
    tick(); tick();
    check_val("rst_req", {63'h0, inst_sram_req_o}, 64'h0);
    check_val("rst_valid", {63'h0, if_to_id_valid_o}, 64'h0);
    check_val("rst_obus", pc_inst_obus, 64'h0);
    check_val("rst_side", {56'h0, if_to_obus}, 64'h0);

    // 1: back-to-back fetches, addr_ok immediate, data_ok one cycle later
    id_allowin_i = 1'b1;
    delay = 1;
    budget = 3;
    for (int i = 0; i < 3; i++) begin
      exp_addr_q.push_back(32'h1C000000 + 32'(4 * i));
      push_pres(32'h1C000000 + 32'(4 * i), rd_of(32'h1C000000 + 32'(4 * i)), 8'h00);
    end
    rst_n = 1'b0;
    #1;
    check_val("first_req", {63'h0, inst_sram_req_o}, 64'h1);
    check_val("first_addr", {32'h0, inst_sram_addr_o}, 64'h1C000000);
    wait_pres(1, 20);
    check_val("latency_grant_to_valid", 64'(lat_last), 64'd2);
    wait_pres(3, 30);
    tick(); tick();
    check_val("grant_spacing", 64'(grant_gap), 64'd3);

    // 2: ID stalls for 5 cycles while a fetch is held
    id_allowin_i = 1'b0;
    exp_addr_q.push_back(32'h1C00000C);
    push_pres(32'h1C00000C, rd_of(32'h1C00000C), 8'h00);
    budget = 1;
    wait_pres(4, 20);
    repeat (5) tick();
    check_val("stall_valid", {63'h0, if_to_id_valid_o}, 64'h1);
    id_allowin_i = 1'b1;
    tick();
    check_val("after_stall_valid", {63'h0, if_to_id_valid_o}, 64'h0);
    check_val("after_stall_req", {63'h0, inst_sram_req_o}, 64'h1);
    check_val("after_stall_addr", {32'h0, inst_sram_addr_o}, 64'h1C000010);

    // 3: branch flush while waiting; the late DEADBEEF response must be dropped
    id_allowin_i = 1'b0;
    g0 = grant_cnt;
    p0 = pres_cnt;
    delay = 4;
    ovr_en = 1'b1;
    ovr_data = 32'hDEADBEEF;
    exp_addr_q.push_back(32'h1C000010);
    budget = 1;
    wait_grant(g0 + 1, 20);
    tick();
    branch_flush_i = 1'b1;
    branch_target_i = 32'h1C000100;
    tick();
    branch_flush_i = 1'b0;
    repeat (4) tick();
    check_val("cancel_no_pres", 64'(pres_cnt), 64'(p0));
    check_val("redirect_addr", {32'h0, inst_sram_addr_o}, 64'h1C000100);
    ovr_en = 1'b0;
    delay = 1;
    exp_addr_q.push_back(32'h1C000100);
    push_pres(32'h1C000100, rd_of(32'h1C000100), 8'h00);
    budget = 1;
    wait_pres(p0 + 1, 20);

    // 4: exception and branch together while holding, with allowin
    tick();
    id_allowin_i = 1'b1;
    excep_flush_i = 1'b1;
    excep_entry_i = 32'h1C008000;
    branch_flush_i = 1'b1;
    branch_target_i = 32'h1C000100;
    tick();
    excep_flush_i = 1'b0;
    branch_flush_i = 1'b0;
    check_val("excep_valid", {63'h0, if_to_id_valid_o}, 64'h0);
    check_val("excep_req", {63'h0, inst_sram_req_o}, 64'h1);
    check_val("excep_addr", {32'h0, inst_sram_addr_o}, 64'h1C008000);

    // 5: flush in the same cycle as addr_ok
    p0 = pres_cnt;
    exp_addr_q.push_back(32'h1C008000);
    exp_addr_q.push_back(32'h1C000200);
    push_pres(32'h1C000200, rd_of(32'h1C000200), 8'h00);
    budget = 2;
    tick();
    branch_flush_i = 1'b1;
    branch_target_i = 32'h1C000200;
    tick();
    branch_flush_i = 1'b0;
    wait_pres(p0 + 1, 20);
    tick(); tick();
    check_val("after_addrok_flush_addr", {32'h0, inst_sram_addr_o}, 64'h1C000204);

    // 6: redirect to a misaligned PC
    p0 = pres_cnt;
    branch_flush_i = 1'b1;
    branch_target_i = 32'h1C000102;
    tick();
    branch_flush_i = 1'b0;
`ifdef IF_ADEF_CHECK_EN
    id_allowin_i = 1'b0;
    push_pres(32'h1C000102, 32'h0, 8'h01);
    check_val("adef_no_req", {63'h0, inst_sram_req_o}, 64'h0);
    wait_pres(p0 + 1, 10);
    tick();
    branch_flush_i = 1'b1;
    branch_target_i = 32'h1C000300;
    tick();
    branch_flush_i = 1'b0;
    check_val("adef_exit_addr", {32'h0, inst_sram_addr_o}, 64'h1C000300);
`else
    check_val("misalign_req", {63'h0, inst_sram_req_o}, 64'h1);
    check_val("misalign_addr", {32'h0, inst_sram_addr_o}, 64'h1C000102);
    exp_addr_q.push_back(32'h1C000102);
    push_pres(32'h1C000102, rd_of(32'h1C000102), 8'h00);
    budget = 1;
    wait_pres(p0 + 1, 20);
`endif
    repeat (3) tick();
    check_val("addr_q_drained", 64'(exp_addr_q.size()), 64'd0);
    check_val("pres_q_drained", 64'(exp_pres_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
